oflow_mem_buffer_mp: RTL and testbench

Parametrised multi-port history-frame buffer for the oflow tracking core. It stores per-bbox feature vectors for the current frame being filled plus up to HISTORY_DEPTH committed past frames in a circular slot array. NUM_RD read ports (one per PE) address data relative to the newest committed frame, with per-port hit/miss. Generalises the two-port buffer with configurable width, depth and port count, a runtime fallback limit, commit handshake and protocol-error reporting.

---
 rtl/oflow_mem_buffer_mp.sv | 168 ++++++++++++++++
 tb/tb_oflow_mem_buffer_mp.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/oflow_mem_buffer_mp.sv
// Multi-port history-frame buffer: one frame slot being filled plus up to
// HISTORY_DEPTH committed frames in a circular slot array, read relative to the newest.
module oflow_mem_buffer_mp #(
   parameter int DATA_WIDTH    = 112,
   parameter int MAX_BBOXES    = 32,
   parameter int HISTORY_DEPTH = 5,
   parameter int NUM_WR        = 2,
   parameter int NUM_RD        = 4,
   parameter int OFS_W         = $clog2(MAX_BBOXES),
   parameter int HIST_W        = $clog2(HISTORY_DEPTH + 1)
) (
   input  logic                               clk,
   input  logic                               reset_N,
   input  logic                               start_frame,
   input  logic                               frame_commit,
   input  logic [OFS_W:0]                     commit_count,
   input  logic [HIST_W-1:0]                  num_of_history_frames,
   input  logic [NUM_WR-1:0]                  wr_en,
   input  logic [NUM_WR-1:0][OFS_W-1:0]       wr_offset,
   input  logic [NUM_WR-1:0][DATA_WIDTH-1:0]  wr_data,
   input  logic [NUM_RD-1:0]                  rd_en,
   input  logic [NUM_RD-1:0][HIST_W-1:0]      rd_hist,
   input  logic [NUM_RD-1:0][OFS_W-1:0]       rd_offset,
   output logic [NUM_RD-1:0]                  rd_valid,
   output logic [NUM_RD-1:0]                  rd_hit,
   output logic [NUM_RD-1:0][DATA_WIDTH-1:0]  rd_data,
   output logic [HIST_W-1:0]                  frames_stored,
   output logic                               filling,
   output logic                               proto_err
);

   localparam int SLOTS = HISTORY_DEPTH + 1;
   localparam logic [HIST_W-1:0] LAST_SLOT = HIST_W'(HISTORY_DEPTH);
   localparam logic [HIST_W:0]   SLOTS_W   = (HIST_W + 1)'(SLOTS);
   localparam logic [OFS_W:0]    MAX_CNT   = (OFS_W + 1)'(MAX_BBOXES);

   typedef enum logic {IDLE, FILL} state_t;

   state_t              state_reg, state_next;
   logic [HIST_W-1:0]   wr_slot_reg, wr_slot_next;
   logic [HIST_W-1:0]   newest_slot_reg;
   logic [HIST_W-1:0]   frames_stored_reg;
   logic [OFS_W:0]      slot_count_reg [SLOTS];
   logic                proto_err_reg, proto_err_next;
   logic                do_commit;
   logic                do_open;

   logic [DATA_WIDTH-1:0] mem [SLOTS][MAX_BBOXES];

   function automatic logic [HIST_W-1:0] slot_inc(input logic [HIST_W-1:0] s);
      return (s == LAST_SLOT) ? '0 : s + 1'b1;
   endfunction

   always_ff @(posedge clk or negedge reset_N) begin
      if (!reset_N) state_reg <= IDLE;
      else          state_reg <= state_next;
   end

   always_comb begin
      state_next     = state_reg;
      do_commit      = 1'b0;
      do_open        = 1'b0;
      proto_err_next = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start_frame) begin
               state_next = FILL;
               do_open    = 1'b1;
            end
            if (frame_commit || (|wr_en)) proto_err_next = 1'b1;
         end
         FILL: begin
            if (frame_commit) begin
               do_commit = 1'b1;
               if (start_frame) do_open = 1'b1;
               else             state_next = IDLE;
            end else if (start_frame) begin
               proto_err_next = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Back-to-back commit+open follows the slot just committed, not the old newest.
   always_comb begin
      wr_slot_next = wr_slot_reg;
      if (do_open) begin
         if (do_commit)                 wr_slot_next = slot_inc(wr_slot_reg);
         else if (frames_stored_reg == '0) wr_slot_next = '0;
         else                           wr_slot_next = slot_inc(newest_slot_reg);
      end
   end

   always_ff @(posedge clk or negedge reset_N) begin
      if (!reset_N) begin
         wr_slot_reg       <= '0;
         newest_slot_reg   <= '0;
         frames_stored_reg <= '0;
         proto_err_reg     <= 1'b0;
         for (int s = 0; s < SLOTS; s++) slot_count_reg[s] <= '0;
      end else begin
         wr_slot_reg   <= wr_slot_next;
         proto_err_reg <= proto_err_next;
         if (do_commit) begin
            slot_count_reg[wr_slot_reg] <= (commit_count > MAX_CNT) ? MAX_CNT : commit_count;
            newest_slot_reg             <= wr_slot_reg;
            if (frames_stored_reg != LAST_SLOT)
               frames_stored_reg <= frames_stored_reg + 1'b1;
         end
      end
   end

   // Later ports overwrite earlier ones on an offset collision.
   always_ff @(posedge clk) begin
      for (int k = 0; k < NUM_WR; k++) begin
         if (wr_en[k] && (state_reg == FILL) && (32'(wr_offset[k]) < MAX_BBOXES))
            mem[wr_slot_reg][wr_offset[k]] <= wr_data[k];
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
         logic                  in_range;
         logic                  hit;
         logic [HIST_W:0]       wrapped;
         logic [HIST_W-1:0]     slot;
         logic                  valid_reg;
         logic                  hit_reg;
         logic [DATA_WIDTH-1:0] data_reg;

         assign in_range = (rd_hist[gi] < frames_stored_reg) &&
                           (rd_hist[gi] < num_of_history_frames);
         assign wrapped  = {1'b0, newest_slot_reg} + SLOTS_W - {1'b0, rd_hist[gi]};

         always_comb begin
            slot = '0;
            if (in_range) begin
               if (rd_hist[gi] <= newest_slot_reg) slot = newest_slot_reg - rd_hist[gi];
               else                                slot = wrapped[HIST_W-1:0];
            end
         end

         assign hit = in_range && ({1'b0, rd_offset[gi]} < slot_count_reg[slot]);

         always_ff @(posedge clk or negedge reset_N) begin
            if (!reset_N) begin
               valid_reg <= 1'b0;
               hit_reg   <= 1'b0;
               data_reg  <= '0;
            end else begin
               valid_reg <= rd_en[gi];
               hit_reg   <= rd_en[gi] && hit;
               data_reg  <= (rd_en[gi] && hit) ? mem[slot][rd_offset[gi]] : '0;
            end
         end

         assign rd_valid[gi] = valid_reg;
         assign rd_hit[gi]   = hit_reg;
         assign rd_data[gi]  = data_reg;
      end
   endgenerate

   assign frames_stored = frames_stored_reg;
   assign filling       = (state_reg == FILL);
   assign proto_err     = proto_err_reg;

endmodule

// File: tb/tb_oflow_mem_buffer_mp.sv
// Directed scoreboard bench: reads push expected responses, a negedge monitor pops and compares.
module tb_oflow_mem_buffer_mp;

   localparam int DW = 112;
   localparam int MB = 32;
   localparam int HD = 5;
   localparam int NW = 2;
   localparam int NR = 4;
   localparam int OW = $clog2(MB);
   localparam int HW = $clog2(HD + 1);

   logic                      clk = 1'b0;
   logic                      reset_N;
   logic                      start_frame;
   logic                      frame_commit;
   logic [OW:0]               commit_count;
   logic [HW-1:0]             num_of_history_frames;
   logic [NW-1:0]             wr_en;
   logic [NW-1:0][OW-1:0]     wr_offset;
   logic [NW-1:0][DW-1:0]     wr_data;
   logic [NR-1:0]             rd_en;
   logic [NR-1:0][HW-1:0]     rd_hist;
   logic [NR-1:0][OW-1:0]     rd_offset;
   logic [NR-1:0]             rd_valid;
   logic [NR-1:0]             rd_hit;
   logic [NR-1:0][DW-1:0]     rd_data;
   logic [HW-1:0]             frames_stored;
   logic                      filling;
   logic                      proto_err;

   typedef struct {
      int            port;
      logic          hit;
      logic [DW-1:0] data;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   oflow_mem_buffer_mp #(
      .DATA_WIDTH(DW), .MAX_BBOXES(MB), .HISTORY_DEPTH(HD),
      .NUM_WR(NW), .NUM_RD(NR), .OFS_W(OW), .HIST_W(HW)
   ) dut (
      .clk(clk), .reset_N(reset_N), .start_frame(start_frame),
      .frame_commit(frame_commit), .commit_count(commit_count),
      .num_of_history_frames(num_of_history_frames),
      .wr_en(wr_en), .wr_offset(wr_offset), .wr_data(wr_data),
      .rd_en(rd_en), .rd_hist(rd_hist), .rd_offset(rd_offset),
      .rd_valid(rd_valid), .rd_hit(rd_hit), .rd_data(rd_data),
      .frames_stored(frames_stored), .filling(filling), .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset_N) begin
         for (int i = 0; i < NR; i++) begin
            if (rd_valid[i]) begin
               if (sb.size() == 0) begin
                  check("unexpected_rd_valid", 128'(i), 128'hFFFF);
               end else begin
                  exp_t e;
                  e = sb.pop_front();
                  $display("RD port=%0d hit=%0b data=%0h (exp hit=%0b data=%0h)",
                           i, rd_hit[i], rd_data[i], e.hit, e.data);
                  check("rd_port", 128'(i), 128'(e.port));
                  check("rd_hit", 128'(rd_hit[i]), 128'(e.hit));
                  check("rd_data", 128'(rd_data[i]), 128'(e.data));
               end
            end else begin
               check("idle_rd_hit", 128'(rd_hit[i]), 128'd0);
               check("idle_rd_data", 128'(rd_data[i]), 128'd0);
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic go();
      cyc();
      rd_en        = '0;
      frame_commit = 1'b0;
      start_frame  = 1'b0;
      wr_en        = '0;
   endtask

   task automatic start();
      start_frame = 1'b1;
      go();
   endtask

   task automatic write1(input int p, input int ofs, input logic [DW-1:0] d);
      wr_en[p]     = 1'b1;
      wr_offset[p] = OW'(ofs);
      wr_data[p]   = d;
      go();
   endtask

   task automatic commit(input int cnt);
      frame_commit = 1'b1;
      commit_count = (OW + 1)'(cnt);
      go();
   endtask

   task automatic rd(input int p, input int h, input int ofs, input logic hit, input logic [DW-1:0] d);
      rd_en[p]     = 1'b1;
      rd_hist[p]   = HW'(h);
      rd_offset[p] = OW'(ofs);
      sb.push_back('{port: p, hit: hit, data: d});
      $display("ISSUE rd port=%0d hist=%0d ofs=%0d", p, h, ofs);
   endtask

   initial begin
      reset_N = 1'b0;
      start_frame = 1'b0; frame_commit = 1'b0; commit_count = '0;
      num_of_history_frames = '0;
      wr_en = '0; wr_offset = '0; wr_data = '0;
      rd_en = '0; rd_hist = '0; rd_offset = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_rd_valid", 128'(rd_valid), 128'd0);
      check("rst_rd_hit", 128'(rd_hit), 128'd0);
      check("rst_rd_data", 128'(rd_data), 128'd0);
      check("rst_frames_stored", 128'(frames_stored), 128'd0);
      check("rst_filling", 128'(filling), 128'd0);
      check("rst_proto_err", 128'(proto_err), 128'd0);
      @(negedge clk) reset_N = 1'b1;
      cyc();
      num_of_history_frames = 3'd5;

      // first frame: rows 0..2
      start();
      check("filling_after_start", 128'(filling), 128'd1);
      for (int i = 0; i < 3; i++) write1(0, i, DW'('hA0 + i));
      commit(3);
      check("frames_stored_1", 128'(frames_stored), 128'd1);
      check("filling_after_commit", 128'(filling), 128'd0);
      rd(0, 0, 1, 1'b1, DW'('hA1)); go();
      rd(1, 0, 3, 1'b0, '0); rd(2, 1, 0, 1'b0, '0); go();

      // seven more frames, row0 = frame number, wraps the 6 slots
      for (int f = 1; f <= 7; f++) begin
         start();
         write1(0, 0, DW'(f));
         commit(1);
      end
      check("frames_stored_sat", 128'(frames_stored), 128'd5);
      for (int p = 0; p < 4; p++) rd(p, p, 0, 1'b1, DW'(7 - p));
      go();
      rd(0, 4, 0, 1'b1, DW'(3)); rd(1, 5, 0, 1'b0, '0); go();

      // runtime history limit
      num_of_history_frames = 3'd2;
      rd(0, 2, 0, 1'b0, '0); go();
      num_of_history_frames = 3'd3;
      rd(0, 2, 0, 1'b1, DW'(5)); go();
      num_of_history_frames = 3'd5;

      // protocol errors
      frame_commit = 1'b1; go();
      check("proto_err_commit_idle", 128'(proto_err), 128'd1);
      cyc();
      check("proto_err_clears", 128'(proto_err), 128'd0);
      write1(0, 3, DW'('hFF));
      check("proto_err_write_idle", 128'(proto_err), 128'd1);
      start();
      check("proto_err_start_idle", 128'(proto_err), 128'd0);
      wr_en = 2'b11; wr_offset[0] = 5'd4; wr_offset[1] = 5'd4;
      wr_data[0] = DW'('h11); wr_data[1] = DW'('h22);
      go();
      start();
      check("proto_err_start_fill", 128'(proto_err), 128'd1);
      check("filling_kept", 128'(filling), 128'd1);
      commit(5);
      rd(0, 0, 4, 1'b1, DW'('h22)); go();

      // commit_count clamps to MAX_BBOXES
      start();
      write1(1, 31, DW'('h5A));
      commit(40);
      rd(0, 0, 31, 1'b1, DW'('h5A)); rd(1, 1, 4, 1'b1, DW'('h22)); go();

      // commit and start together, then a read in a commit cycle
      start();
      write1(0, 0, DW'('h77));
      frame_commit = 1'b1; commit_count = 6'd1; start_frame = 1'b1; go();
      check("filling_commit_start", 128'(filling), 128'd1);
      check("proto_err_commit_start", 128'(proto_err), 128'd0);
      write1(0, 0, DW'('h88));
      frame_commit = 1'b1; commit_count = 6'd1;
      rd(0, 0, 0, 1'b1, DW'('h77)); rd(1, 1, 31, 1'b1, DW'('h5A)); go();
      rd(0, 0, 0, 1'b1, DW'('h88)); rd(1, 1, 0, 1'b1, DW'('h77)); go();
      cyc();

      // asynchronous reset in the middle of a fill
      start();
      write1(0, 2, DW'('h99));
      #2 reset_N = 1'b0;
      #1;
      check("mid_rst_rd_valid", 128'(rd_valid), 128'd0);
      check("mid_rst_rd_data", 128'(rd_data), 128'd0);
      check("mid_rst_frames_stored", 128'(frames_stored), 128'd0);
      check("mid_rst_filling", 128'(filling), 128'd0);
      check("mid_rst_proto_err", 128'(proto_err), 128'd0);
      @(negedge clk) reset_N = 1'b1;
      cyc();
      rd(0, 0, 0, 1'b0, '0); go();

      repeat (3) cyc();
      check("scoreboard_drained", 128'(sb.size()), 128'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
